pipe_mem_ctrl: RTL and testbench
================================

# pipe_mem_ctrl

Pipeline stall and memory-sequencing controller for the Vec_CPU. It drives the enable and clear inputs of the inter-stage control/data registers (PC, IF/ID, ID/EX, EX/MEM). It serialises scalar and vector memory operations held in EX onto the single-element memory port, one lane per handshake. It also applies branch flushes and a debug halt with fixed priority.

## Interface
- LANES, 4, elements per vector memory op (power of two, ≥2)
- LW, $clog2(LANES), lane index width (derived, not overridable)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- ex_valid  in  1  EX stage holds a valid instruction
- ex_cl_mem_op  in  2  00 none, 01 scalar, 10 vector, 11 reserved (treated as none)
- ex_cl_mem_st  in  1  1 store, 0 load
- branch_taken  in  1  EX branch resolved taken (qualified by ex_valid)
- halt  in  1  debug halt request
- mem_ready  in  1  memory accepts/completes current element this cycle
- mem_req  out  1  element access request
- mem_we  out  1  write enable (= ex_cl_mem_st while mem_req)
- mem_lane  out  LW  lane index of current element
- ld_lane_we  out  1  load data for mem_lane valid; capture into vector/scalar result
- en_pc, en_if_id, en_id_ex, en_ex_mem  out  1 each  register enables
- clr_if_id, clr_id_ex, clr_ex_mem  out  1 each  synchronous bubble insert (clear has priority over enable at the register)
- busy  out  1  FSM not IDLE

## Operation
- States: IDLE, ACCESS, DONE. Lane counter `lane` (LW bits). State and lane are the only flops.
- mem_go = ex_valid & (ex_cl_mem_op==01 | ex_cl_mem_op==10).
- IDLE:
  - If halt: all en_* = 0 and all clr_* = 0 (freeze).
  - Else if mem_go: en_pc = en_if_id = en_id_ex = en_ex_mem = 0, clr_ex_mem = 1; next ACCESS, lane = 0.
  - Else: all en_* = 1.
- ACCESS:
  - Front enables stay 0, clr_ex_mem = 1, mem_req = 1, mem_lane = lane.
  - On mem_ready: ld_lane_we = ~ex_cl_mem_st. If lane == last, go to DONE; otherwise lane increments.
  - last = 0 for scalar, LANES-1 for vector.
  - If mem_ready is low, hold lane and mem_req.
- DONE: all en_* = 1, mem_req = 0. The op leaves EX. Next state is IDLE; DONE exists so the op is not re-triggered.
- Flush: when ex_valid & branch_taken and the front is enabled (IDLE without mem_go/halt, or DONE), assert clr_if_id = clr_id_ex = 1.
- Priority: halt (IDLE only) > mem_go > branch.
  - Branch plus mem op in the same instruction: the flush is deferred to the DONE cycle, where branch_taken is still presented because EX was held.
  - halt during ACCESS/DONE is ignored until the next IDLE. In-flight ops always complete.
- ex_cl_mem_op/ex_cl_mem_st are required stable while busy, since EX is frozen.
- lane wraps only via reset to 0 on DONE→IDLE. It never increments past last.

## Timing
- Reset (rst_n low, asynchronous): state IDLE, lane 0. All outputs 0 (enables and clears gated low), including mem_req, mem_we, mem_lane, ld_lane_we, busy.
- Reset mid-ACCESS: mem_req drops in the same cycle. After release, if EX still holds the op, sequencing restarts at lane 0.
- Outputs are combinational from state, lane and inputs. There is no output register.
- EX occupancy with mem_ready tied 1: scalar 3 cycles (IDLE, ACCESS, DONE), vector LANES+2 cycles. Each mem_ready-low cycle adds one.
- mem_req/mem_lane/mem_we are stable until the mem_ready handshake completes.

## Structure
- In vec_cpu_pkg:
  - mem_op_e enum (MEM_NONE, MEM_SCALAR, MEM_VECTOR, MEM_RSVD).
  - pmc_state_e (IDLE, ACCESS, DONE).
  - Default LANES constant, shared with the lane datapath.
- Single module. No sub-module: the lane counter is a few lines inside the FSM.

## Test plan
- Reset/idle: assert rst_n low → all outputs 0. Release with ex_valid=0 → en_* = 1, clr_* = 0, busy = 0.
- Scalar load, mem_ready=1:
  - c0: en_* = 0, clr_ex_mem = 1.
  - c1: mem_req = 1, lane 0, ld_lane_we = 1.
  - c2: DONE, en_* = 1.
  - c3: IDLE.
- Vector store, LANES=4, mem_ready low 2 cycles at lane 2: mem_lane sequence 0,1,2,2,2,3 with mem_we = 1 and ld_lane_we = 0. EX held 8 cycles.
- Branch without mem op → clr_if_id = clr_id_ex = 1 for one cycle, en_* = 1. Same branch with vector op → no flush until DONE, then a single-cycle flush.
- halt asserted in IDLE → all en_* / clr_* = 0. halt asserted at lane 1 of a vector op → lanes complete through DONE, freeze starts the next cycle.
- rst_n low at lane 2 → mem_req = 0 immediately. After release with op held, mem_lane restarts at 0.

Source files
------------

// File: rtl/vec_cpu_pkg.sv
// Shared types and constants for the Vec_CPU control path.
package vec_cpu_pkg;

  // Lane count shared by the memory sequencer and the lane datapath.
  localparam int unsigned VEC_LANES = 4;

  typedef enum logic [1:0] {
    MEM_NONE   = 2'b00,
    MEM_SCALAR = 2'b01,
    MEM_VECTOR = 2'b10,
    MEM_RSVD   = 2'b11
  } mem_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } pmc_state_e;

endpackage

// File: rtl/pipe_mem_ctrl.sv
// Pipeline stall/flush control and lane-serial sequencing of EX memory ops
// onto a single-element memory port.
module pipe_mem_ctrl
  import vec_cpu_pkg::*;
#(
  parameter int unsigned LANES = VEC_LANES,
  localparam int unsigned LW   = $clog2(LANES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ex_valid,
  input  logic [1:0]    ex_cl_mem_op,
  input  logic          ex_cl_mem_st,
  input  logic          branch_taken,
  input  logic          halt,
  input  logic          mem_ready,
  output logic          mem_req,
  output logic          mem_we,
  output logic [LW-1:0] mem_lane,
  output logic          ld_lane_we,
  output logic          en_pc,
  output logic          en_if_id,
  output logic          en_id_ex,
  output logic          en_ex_mem,
  output logic          clr_if_id,
  output logic          clr_id_ex,
  output logic          clr_ex_mem,
  output logic          busy
);

  pmc_state_e    state_q, state_d;
  logic [LW-1:0] lane_q, lane_d;

  mem_op_e       op;
  logic          mem_go;
  logic          flush;
  logic [LW-1:0] last;

  assign op     = mem_op_e'(ex_cl_mem_op);
  assign mem_go = ex_valid & ((op == MEM_SCALAR) | (op == MEM_VECTOR));
  assign flush  = ex_valid & branch_taken;
  assign last   = (op == MEM_VECTOR) ? LW'(LANES - 1) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_lane   = '0;
    ld_lane_we = 1'b0;
    en_pc      = 1'b0;
    en_if_id   = 1'b0;
    en_id_ex   = 1'b0;
    en_ex_mem  = 1'b0;
    clr_if_id  = 1'b0;
    clr_id_ex  = 1'b0;
    clr_ex_mem = 1'b0;
    busy       = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (halt) begin
          // Full freeze: nothing moves, nothing is cleared.
        end else if (mem_go) begin
          clr_ex_mem = 1'b1;
          state_d    = ACCESS;
          lane_d     = '0;
        end else begin
          {en_pc, en_if_id, en_id_ex, en_ex_mem} = 4'hF;
          clr_if_id = flush;
          clr_id_ex = flush;
        end
      end
      ACCESS: begin
        clr_ex_mem = 1'b1;
        mem_req    = 1'b1;
        mem_we     = ex_cl_mem_st;
        mem_lane   = lane_q;
        if (mem_ready) begin
          ld_lane_we = ~ex_cl_mem_st;
          if (lane_q == last) state_d = DONE;
          else                lane_d  = lane_q + 1'b1;
        end
      end
      DONE: begin
        // Deferred branch flush lands here since EX was held during the op.
        {en_pc, en_if_id, en_id_ex, en_ex_mem} = 4'hF;
        clr_if_id = flush;
        clr_id_ex = flush;
        state_d   = IDLE;
        lane_d    = '0;
      end
      default: begin
        state_d = IDLE;
        lane_d  = '0;
      end
    endcase

    // Outputs are forced low while reset is held, regardless of inputs.
    if (!rst_n) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_lane   = '0;
      ld_lane_we = 1'b0;
      en_pc      = 1'b0;
      en_if_id   = 1'b0;
      en_id_ex   = 1'b0;
      en_ex_mem  = 1'b0;
      clr_if_id  = 1'b0;
      clr_id_ex  = 1'b0;
      clr_ex_mem = 1'b0;
      busy       = 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_mem_ctrl.sv
// Directed bench for pipe_mem_ctrl: per-cycle expected output words are queued
// by the stimulus and checked by an independent monitor on the falling edge.
module tb_pipe_mem_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ex_valid = 1'b0;
  logic [1:0] ex_cl_mem_op = 2'b00;
  logic       ex_cl_mem_st = 1'b0;
  logic       branch_taken = 1'b0;
  logic       halt = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, ld_lane_we, busy;
  logic [1:0] mem_lane;
  logic       en_pc, en_if_id, en_id_ex, en_ex_mem;
  logic       clr_if_id, clr_id_ex, clr_ex_mem;

  pipe_mem_ctrl #(.LANES(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid     (ex_valid),
    .ex_cl_mem_op (ex_cl_mem_op),
    .ex_cl_mem_st (ex_cl_mem_st),
    .branch_taken (branch_taken),
    .halt         (halt),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_lane     (mem_lane),
    .ld_lane_we   (ld_lane_we),
    .en_pc        (en_pc),
    .en_if_id     (en_if_id),
    .en_id_ex     (en_id_ex),
    .en_ex_mem    (en_ex_mem),
    .clr_if_id    (clr_if_id),
    .clr_id_ex    (clr_id_ex),
    .clr_ex_mem   (clr_ex_mem),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // {mem_req, mem_we, mem_lane[1:0], ld_lane_we, en_pc, en_if_id, en_id_ex, en_ex_mem,
  //  clr_if_id, clr_id_ex, clr_ex_mem, busy}
  typedef struct {
    string      name;
    logic [12:0] exp;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;

  localparam logic [12:0] Zero = 13'h0000;
  localparam logic [12:0] Hold = 13'h0002;

  function automatic logic [12:0] f_run(input logic fl);
    return {5'b00000, 4'hF, fl, fl, 1'b0, 1'b0};
  endfunction

  function automatic logic [12:0] f_done(input logic fl);
    return {5'b00000, 4'hF, fl, fl, 1'b0, 1'b1};
  endfunction

  function automatic logic [12:0] f_acc(input logic [1:0] l, input logic we, input logic ld);
    return {1'b1, we, l, ld, 4'h0, 2'b00, 1'b1, 1'b1};
  endfunction

  task automatic cyc(input logic r, input logic v, input logic [1:0] op, input logic st,
                     input logic br, input logic h, input logic rdy, input logic [12:0] e,
                     input string nm);
    @(posedge clk);
    #1;
    rst_n        = r;
    ex_valid     = v;
    ex_cl_mem_op = op;
    ex_cl_mem_st = st;
    branch_taken = br;
    halt         = h;
    mem_ready    = rdy;
    q.push_back('{nm, e});
  endtask

  always @(negedge clk) begin
    logic [12:0] act;
    exp_t        e;
    if (q.size() > 0) begin
      e   = q.pop_front();
      act = {mem_req, mem_we, mem_lane, ld_lane_we, en_pc, en_if_id, en_id_ex, en_ex_mem,
             clr_if_id, clr_id_ex, clr_ex_mem, busy};
      checks++;
      if (act === e.exp) passes++;
      else $display("FAIL %s: got %b expected %b", e.name, act, e.exp);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset: outputs low regardless of inputs
    cyc(0, 1, 2'b10, 1, 1, 0, 1, Zero, "reset_vec");
    cyc(0, 0, 2'b00, 0, 0, 0, 1, Zero, "reset_idle");
    cyc(1, 0, 2'b00, 0, 0, 0, 1, f_run(0), "idle_run");
    cyc(1, 0, 2'b10, 0, 0, 0, 1, f_run(0), "op_not_valid");

    // Scalar load, ready tied high
    cyc(1, 1, 2'b01, 0, 0, 0, 1, Hold, "sc_c0");
    cyc(1, 1, 2'b01, 0, 0, 0, 1, f_acc(0, 0, 1), "sc_c1");
    cyc(1, 1, 2'b01, 0, 0, 0, 1, f_done(0), "sc_c2");
    cyc(1, 0, 2'b00, 0, 0, 0, 1, f_run(0), "sc_c3");

    // Vector store with two wait cycles at lane 2 (EX held 8 cycles)
    cyc(1, 1, 2'b10, 1, 0, 0, 1, Hold, "vs_c0");
    cyc(1, 1, 2'b10, 1, 0, 0, 1, f_acc(0, 1, 0), "vs_l0");
    cyc(1, 1, 2'b10, 1, 0, 0, 1, f_acc(1, 1, 0), "vs_l1");
    cyc(1, 1, 2'b10, 1, 0, 0, 0, f_acc(2, 1, 0), "vs_l2w0");
    cyc(1, 1, 2'b10, 1, 0, 0, 0, f_acc(2, 1, 0), "vs_l2w1");
    cyc(1, 1, 2'b10, 1, 0, 0, 1, f_acc(2, 1, 0), "vs_l2");
    cyc(1, 1, 2'b10, 1, 0, 0, 1, f_acc(3, 1, 0), "vs_l3");
    cyc(1, 1, 2'b10, 1, 0, 0, 1, f_done(0), "vs_done");
    cyc(1, 0, 2'b00, 0, 0, 0, 1, f_run(0), "vs_idle");

    // Vector load, one wait at lane 1: load strobe only on handshake
    cyc(1, 1, 2'b10, 0, 0, 0, 1, Hold, "vl_c0");
    cyc(1, 1, 2'b10, 0, 0, 0, 1, f_acc(0, 0, 1), "vl_l0");
    cyc(1, 1, 2'b10, 0, 0, 0, 0, f_acc(1, 0, 0), "vl_l1w");
    cyc(1, 1, 2'b10, 0, 0, 0, 1, f_acc(1, 0, 1), "vl_l1");
    cyc(1, 1, 2'b10, 0, 0, 0, 1, f_acc(2, 0, 1), "vl_l2");
    cyc(1, 1, 2'b10, 0, 0, 0, 1, f_acc(3, 0, 1), "vl_l3");
    cyc(1, 1, 2'b10, 0, 0, 0, 1, f_done(0), "vl_done");
    cyc(1, 0, 2'b00, 0, 0, 0, 1, f_run(0), "vl_idle");

    // Branch without mem op, and with reserved op (treated as none)
    cyc(1, 1, 2'b00, 0, 1, 0, 1, f_run(1), "br_flush");
    cyc(1, 0, 2'b00, 0, 0, 0, 1, f_run(0), "br_after");
    cyc(1, 1, 2'b11, 0, 1, 0, 1, f_run(1), "br_rsvd");
    cyc(1, 0, 2'b00, 0, 1, 0, 1, f_run(0), "br_not_valid");

    // Branch with vector op: flush deferred to DONE
    cyc(1, 1, 2'b10, 1, 1, 0, 1, Hold, "bv_c0");
    cyc(1, 1, 2'b10, 1, 1, 0, 1, f_acc(0, 1, 0), "bv_l0");
    cyc(1, 1, 2'b10, 1, 1, 0, 1, f_acc(1, 1, 0), "bv_l1");
    cyc(1, 1, 2'b10, 1, 1, 0, 1, f_acc(2, 1, 0), "bv_l2");
    cyc(1, 1, 2'b10, 1, 1, 0, 1, f_acc(3, 1, 0), "bv_l3");
    cyc(1, 1, 2'b10, 1, 1, 0, 1, f_done(1), "bv_done");
    cyc(1, 0, 2'b00, 0, 0, 0, 1, f_run(0), "bv_idle");

    // Halt in IDLE freezes, and beats a pending mem op
    cyc(1, 0, 2'b00, 0, 0, 1, 1, Zero, "halt_idle");
    cyc(1, 1, 2'b01, 0, 1, 1, 1, Zero, "halt_memgo");
    cyc(1, 1, 2'b01, 1, 0, 0, 1, Hold, "halt_rel_c0");
    cyc(1, 1, 2'b01, 1, 0, 0, 1, f_acc(0, 1, 0), "halt_rel_acc");
    cyc(1, 1, 2'b01, 1, 0, 0, 1, f_done(0), "halt_rel_done");

    // Halt raised at lane 1 of a vector op: op completes, freeze after
    cyc(1, 1, 2'b10, 0, 0, 0, 1, Hold, "hv_c0");
    cyc(1, 1, 2'b10, 0, 0, 0, 1, f_acc(0, 0, 1), "hv_l0");
    cyc(1, 1, 2'b10, 0, 0, 1, 1, f_acc(1, 0, 1), "hv_l1");
    cyc(1, 1, 2'b10, 0, 0, 1, 1, f_acc(2, 0, 1), "hv_l2");
    cyc(1, 1, 2'b10, 0, 0, 1, 1, f_acc(3, 0, 1), "hv_l3");
    cyc(1, 1, 2'b10, 0, 0, 1, 1, f_done(0), "hv_done");
    cyc(1, 0, 2'b00, 0, 0, 1, 1, Zero, "hv_freeze");
    cyc(1, 0, 2'b00, 0, 0, 0, 1, f_run(0), "hv_unfreeze");

    // Reset at lane 2 drops mem_req at once; sequencing restarts at lane 0
    cyc(1, 1, 2'b10, 1, 0, 0, 1, Hold, "rs_c0");
    cyc(1, 1, 2'b10, 1, 0, 0, 1, f_acc(0, 1, 0), "rs_l0");
    cyc(1, 1, 2'b10, 1, 0, 0, 1, f_acc(1, 1, 0), "rs_l1");
    cyc(0, 1, 2'b10, 1, 0, 0, 1, Zero, "rs_mid");
    cyc(1, 1, 2'b10, 1, 0, 0, 1, Hold, "rs_re_c0");
    cyc(1, 1, 2'b10, 1, 0, 0, 1, f_acc(0, 1, 0), "rs_re_l0");
    cyc(1, 1, 2'b10, 1, 0, 0, 1, f_acc(1, 1, 0), "rs_re_l1");
    cyc(1, 1, 2'b10, 1, 0, 0, 1, f_acc(2, 1, 0), "rs_re_l2");
    cyc(1, 1, 2'b10, 1, 0, 0, 1, f_acc(3, 1, 0), "rs_re_l3");
    cyc(1, 1, 2'b10, 1, 0, 0, 1, f_done(0), "rs_re_done");
    cyc(1, 0, 2'b00, 0, 0, 0, 1, f_run(0), "rs_re_idle");

    @(posedge clk);
    @(posedge clk);
    checks++;
    if (q.size() == 0) passes++;
    else $display("FAIL drain: %0d expectations left, expected 0", q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
